// File: rtl/bmp280_pkg.sv
// Shared constants and types for the BMP280 register-subset I2C target.
// Register addresses, the soft-reset magic value and the target FSM states.
package bmp280_pkg;

    localparam logic [7:0] CALIB_BASE    = 8'h88;
    localparam int         CALIB_BYTES   = 26;
    localparam logic [7:0] CHIP_ID_REG   = 8'hD0;
    localparam logic [7:0] RESET_REG     = 8'hE0;
    localparam logic [7:0] STATUS_REG    = 8'hF3;
    localparam logic [7:0] CTRL_MEAS_REG = 8'hF4;
    localparam logic [7:0] CONFIG_REG    = 8'hF5;
    localparam logic [7:0] PRESS_MSB     = 8'hF7;
    localparam logic [7:0] PRESS_LSB     = 8'hF8;
    localparam logic [7:0] PRESS_XLSB    = 8'hF9;
    localparam logic [7:0] TEMP_MSB      = 8'hFA;
    localparam logic [7:0] TEMP_LSB      = 8'hFB;
    localparam logic [7:0] TEMP_XLSB     = 8'hFC;
    localparam logic [7:0] RESET_MAGIC   = 8'hB6;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK      = 4'd8,
        ST_IGNORE    = 4'd9,
        ST_WAIT_STOP = 4'd10
    } i2c_state_e;

    // A 20-bit raw sample as seen through the MSB / LSB / XLSB register triple
    function automatic logic [7:0] raw_byte(input logic [19:0] raw, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = raw[19:12];
            2'd1:    b = raw[11:4];
            default: b = {raw[3:0], 4'h0};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C pin front end: synchronizers, registered SCL edge strobes and START/STOP detection.
// Shared by target and controller designs; strobes are one clk wide.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_hist_r;
    logic                   sda_hist_r;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_r[SYNC_STAGES-1];
    assign sda_s = sda_sync_r[SYNC_STAGES-1];

    // Synchronizer chain plus history flop; everything resets to the idle-high bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_hist_r <= 1'b1;
            sda_hist_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
            scl_hist_r <= scl_s;
            sda_hist_r <= sda_s;
        end
    end

    // Registered event strobes; sda is delayed alongside so it is the level at the edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sda       <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            sda       <= sda_s;
            scl_rise  <= scl_s & ~scl_hist_r;
            scl_fall  <= ~scl_s & scl_hist_r;
            start_det <= scl_s & scl_hist_r & sda_hist_r & ~sda_s;
            stop_det  <= scl_s & scl_hist_r & ~sda_hist_r & sda_s;
        end
    end

endmodule

// File: rtl/bmp280_i2c_target.sv
// I2C target emulating the BMP280 register subset (calibration, ID, reset, ctrl_meas, data).
// Measurement inputs are shadowed on every START so a burst returns one coherent sample.
module bmp280_i2c_target
    import bmp280_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h76,
    parameter logic [7:0] CHIP_ID     = 8'h58,
    parameter int         SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         scl_i,
    input  logic         sda_i,
    output logic         sda_oe,
    input  logic [19:0]  temp_raw,
    input  logic [19:0]  press_raw,
    input  logic [207:0] calib_data,
    output logic [7:0]   ctrl_meas,
    output logic         soft_reset,
    output logic         busy
);

    logic       bus_sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    logic       rise_s, fall_s, addr_match_s, calib_hit_s;
    logic [7:0] calib_byte_s, rd_byte_s;

    i2c_state_e state_r, state_next;
    logic       sda_oe_r, sda_oe_next, busy_r, busy_next, soft_reset_r, soft_reset_next;
    logic       nack_r, nack_next;
    logic [3:0] bit_cnt_r, bit_cnt_next;
    logic [7:0] shift_r, shift_next, tx_r, tx_next, pointer_r, pointer_next;
    logic [7:0] ctrl_meas_r, ctrl_meas_next;
    logic [19:0] temp_sh_r, temp_sh_next, press_sh_r, press_sh_next;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (bus_sda_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_s),
        .stop_det  (stop_s)
    );

    // Bus conditions win over a coincident SCL edge
    assign rise_s       = scl_rise_s & ~start_s & ~stop_s;
    assign fall_s       = scl_fall_s & ~start_s & ~stop_s;
    assign addr_match_s = (shift_r[7:1] == DEV_ADDR);

    assign sda_oe     = sda_oe_r;
    assign busy       = busy_r;
    assign soft_reset = soft_reset_r;
    assign ctrl_meas  = ctrl_meas_r;

    // Calibration window decode as an AND-OR mux over the 26 trim bytes
    always_comb begin
        calib_hit_s  = 1'b0;
        calib_byte_s = 8'h00;
        for (int k = 0; k < CALIB_BYTES; k++) begin
            calib_hit_s  = calib_hit_s | (pointer_r == (CALIB_BASE + 8'(k)));
            calib_byte_s = calib_byte_s
                         | ({8{pointer_r == (CALIB_BASE + 8'(k))}} & calib_data[8*k +: 8]);
        end
    end

    // Read-side register map at the current pointer
    always_comb begin
        rd_byte_s = 8'h00;
        if (calib_hit_s) begin
            rd_byte_s = calib_byte_s;
        end else begin
            case (pointer_r)
                CHIP_ID_REG:   rd_byte_s = CHIP_ID;
                RESET_REG:     rd_byte_s = 8'h00;
                STATUS_REG:    rd_byte_s = 8'h00;
                CTRL_MEAS_REG: rd_byte_s = ctrl_meas_r;
                CONFIG_REG:    rd_byte_s = 8'h00;
                PRESS_MSB:     rd_byte_s = raw_byte(press_sh_r, 2'd0);
                PRESS_LSB:     rd_byte_s = raw_byte(press_sh_r, 2'd1);
                PRESS_XLSB:    rd_byte_s = raw_byte(press_sh_r, 2'd2);
                TEMP_MSB:      rd_byte_s = raw_byte(temp_sh_r, 2'd0);
                TEMP_LSB:      rd_byte_s = raw_byte(temp_sh_r, 2'd1);
                TEMP_XLSB:     rd_byte_s = raw_byte(temp_sh_r, 2'd2);
                default:       rd_byte_s = 8'h00;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sda_oe_r     <= 1'b0;
            busy_r       <= 1'b0;
            soft_reset_r <= 1'b0;
            nack_r       <= 1'b0;
            bit_cnt_r    <= 4'd0;
            shift_r      <= 8'h00;
            tx_r         <= 8'h00;
            pointer_r    <= 8'h00;
            ctrl_meas_r  <= 8'h00;
            temp_sh_r    <= 20'h00000;
            press_sh_r   <= 20'h00000;
        end else begin
            state_r      <= state_next;
            sda_oe_r     <= sda_oe_next;
            busy_r       <= busy_next;
            soft_reset_r <= soft_reset_next;
            nack_r       <= nack_next;
            bit_cnt_r    <= bit_cnt_next;
            shift_r      <= shift_next;
            tx_r         <= tx_next;
            pointer_r    <= pointer_next;
            ctrl_meas_r  <= ctrl_meas_next;
            temp_sh_r    <= temp_sh_next;
            press_sh_r   <= press_sh_next;
        end
    end

    // Next-state logic; byte-level transitions happen on the SCL fall after the 8th bit
    always_comb begin
        state_next = state_r;
        if (stop_s) begin
            state_next = ST_IDLE;
        end else if (start_s) begin
            state_next = ST_ADDR;
        end else begin
            case (state_r)
                ST_ADDR:      if (fall_s && bit_cnt_r == 4'd8)
                                  state_next = addr_match_s ? ST_ADDR_ACK : ST_IGNORE;
                              else state_next = ST_ADDR;
                ST_ADDR_ACK:  state_next = fall_s ? (shift_r[0] ? ST_RDATA : ST_PTR) : ST_ADDR_ACK;
                ST_PTR:       state_next = (fall_s && bit_cnt_r == 4'd8) ? ST_PTR_ACK : ST_PTR;
                ST_PTR_ACK:   state_next = fall_s ? ST_WDATA : ST_PTR_ACK;
                ST_WDATA:     state_next = (fall_s && bit_cnt_r == 4'd8) ? ST_WDATA_ACK : ST_WDATA;
                ST_WDATA_ACK: state_next = fall_s ? ST_WDATA : ST_WDATA_ACK;
                ST_RDATA:     state_next = (fall_s && bit_cnt_r == 4'd8) ? ST_RACK : ST_RDATA;
                ST_RACK:      state_next = fall_s ? (nack_r ? ST_WAIT_STOP : ST_RDATA) : ST_RACK;
                ST_IDLE:      state_next = ST_IDLE;
                ST_IGNORE:    state_next = ST_IGNORE;
                ST_WAIT_STOP: state_next = ST_WAIT_STOP;
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs and datapath: SDA sampled on SCL rise, SDA drive updated on SCL fall
    always_comb begin
        sda_oe_next     = sda_oe_r;
        busy_next       = busy_r;
        soft_reset_next = 1'b0;
        nack_next       = nack_r;
        bit_cnt_next    = bit_cnt_r;
        shift_next      = shift_r;
        tx_next         = tx_r;
        pointer_next    = pointer_r;
        ctrl_meas_next  = ctrl_meas_r;
        temp_sh_next    = temp_sh_r;
        press_sh_next   = press_sh_r;
        if (stop_s) begin
            sda_oe_next = 1'b0;
            busy_next   = 1'b0;
        end else if (start_s) begin
            sda_oe_next   = 1'b0;
            bit_cnt_next  = 4'd0;
            temp_sh_next  = temp_raw;
            press_sh_next = press_raw;
        end else begin
            case (state_r)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (rise_s) begin
                        shift_next   = {shift_r[6:0], bus_sda_s};
                        bit_cnt_next = bit_cnt_r + 4'd1;
                    end else if (fall_s && bit_cnt_r == 4'd8) begin
                        bit_cnt_next = 4'd0;
                        if (state_r != ST_ADDR) begin
                            sda_oe_next = 1'b1;
                        end else if (addr_match_s) begin
                            sda_oe_next = 1'b1;
                            busy_next   = 1'b1;
                        end else begin
                            sda_oe_next = 1'b0;
                        end
                    end else begin
                        shift_next = shift_r;
                    end
                end
                ST_ADDR_ACK: begin
                    if (fall_s && shift_r[0]) begin
                        sda_oe_next = ~rd_byte_s[7];
                        tx_next     = {rd_byte_s[6:0], 1'b0};
                    end else if (fall_s) begin
                        sda_oe_next = 1'b0;
                    end else begin
                        tx_next = tx_r;
                    end
                end
                ST_PTR_ACK: begin
                    if (rise_s) begin
                        pointer_next = shift_r;
                    end else if (fall_s) begin
                        sda_oe_next = 1'b0;
                    end else begin
                        pointer_next = pointer_r;
                    end
                end
                ST_WDATA_ACK: begin
                    if (rise_s) begin
                        pointer_next = pointer_r + 8'd1;
                        if (pointer_r == CTRL_MEAS_REG) begin
                            ctrl_meas_next = shift_r;
                        end else if (pointer_r == RESET_REG && shift_r == RESET_MAGIC) begin
                            ctrl_meas_next  = 8'h00;
                            soft_reset_next = 1'b1;
                        end else begin
                            ctrl_meas_next = ctrl_meas_r;
                        end
                    end else if (fall_s) begin
                        sda_oe_next = 1'b0;
                    end else begin
                        pointer_next = pointer_r;
                    end
                end
                ST_RDATA: begin
                    if (rise_s) begin
                        bit_cnt_next = bit_cnt_r + 4'd1;
                    end else if (fall_s && bit_cnt_r == 4'd8) begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = 4'd0;
                    end else if (fall_s) begin
                        sda_oe_next = ~tx_r[7];
                        tx_next     = {tx_r[6:0], 1'b0};
                    end else begin
                        tx_next = tx_r;
                    end
                end
                ST_RACK: begin
                    if (rise_s) begin
                        nack_next    = bus_sda_s;
                        pointer_next = bus_sda_s ? pointer_r : pointer_r + 8'd1;
                    end else if (fall_s && !nack_r) begin
                        sda_oe_next = ~rd_byte_s[7];
                        tx_next     = {rd_byte_s[6:0], 1'b0};
                    end else if (fall_s) begin
                        sda_oe_next = 1'b0;
                    end else begin
                        nack_next = nack_r;
                    end
                end
                default: sda_oe_next = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_bmp280_i2c_target.sv
// Directed bench: bit-banged I2C controller against the BMP280 target emulation.
// Each task drives one scenario and checks results against hand-computed values.
module tb_bmp280_i2c_target;
    import bmp280_pkg::*;

    localparam int Q = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         scl = 1'b1;
    logic         sda_ctrl = 1'b1;
    logic         sda_line;
    logic         sda_oe;
    logic [19:0]  temp_raw = 20'h00000;
    logic [19:0]  press_raw = 20'h00000;
    logic [207:0] calib_data;
    logic [7:0]   ctrl_meas;
    logic         soft_reset;
    logic         busy;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;
    int oe_cnt = 0;

    assign sda_line = sda_ctrl & ~sda_oe;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (soft_reset) pulse_cnt++;
        if (sda_oe) oe_cnt++;
    end

    bmp280_i2c_target u_dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl),
        .sda_i      (sda_line),
        .sda_oe     (sda_oe),
        .temp_raw   (temp_raw),
        .press_raw  (press_raw),
        .calib_data (calib_data),
        .ctrl_meas  (ctrl_meas),
        .soft_reset (soft_reset),
        .busy       (busy)
    );

    task automatic wq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b1; wq();
        scl = 1'b1;      wq();
        sda_ctrl = 1'b0; wq();
        scl = 1'b0;      wq();
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0; wq();
        scl = 1'b1;      wq();
        sda_ctrl = 1'b1; wq();
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_ctrl = b; wq();
        scl = 1'b1;   wq();
        s = sda_line; wq();
        scl = 1'b0;   wq();
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clock_bit(nack, s);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d, output logic [2:0] acks);
        logic a0, a1, a2;
        i2c_start();
        wr_byte({7'h76, 1'b0}, a0);
        wr_byte(a, a1);
        wr_byte(d, a2);
        i2c_stop();
        acks = {a0, a1, a2};
    endtask

    task automatic read_setup(input logic [7:0] a, output logic [2:0] acks);
        logic a0, a1, a2;
        i2c_start();
        wr_byte({7'h76, 1'b0}, a0);
        wr_byte(a, a1);
        i2c_start();
        wr_byte({7'h76, 1'b1}, a2);
        acks = {a0, a1, a2};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        total++; if (ctrl_meas !== 8'h00) begin bad++; $display("FAIL reset_ctrl_meas: got %h want 00", ctrl_meas); end
        total++; if (soft_reset !== 1'b0) begin bad++; $display("FAIL reset_soft_reset: got %b want 0", soft_reset); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (u_dut.pointer_r !== 8'h00) begin bad++; $display("FAIL reset_pointer: got %h want 00", u_dut.pointer_r); end
    endtask

    task automatic test_chip_id(input string tag);
        logic [2:0] acks;
        logic [7:0] d;
        read_setup(CHIP_ID_REG, acks);
        total++; if (acks !== 3'b000) begin bad++; $display("FAIL %s_acks: got %b want 000", tag, acks); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy: got %b want 1", tag, busy); end
        rd_byte(1'b1, d);
        i2c_stop();
        total++; if (d !== 8'h58) begin bad++; $display("FAIL %s_data: got %h want 58", tag, d); end
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL %s_release: got %b want 0", tag, sda_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_stop: got %b want 0", tag, busy); end
    endtask

    task automatic test_ctrl_meas();
        logic [2:0] acks;
        logic [7:0] d;
        int p0;
        write_reg(CTRL_MEAS_REG, 8'hB7, acks);
        total++; if (acks !== 3'b000) begin bad++; $display("FAIL ctrl_wr_acks: got %b want 000", acks); end
        total++; if (ctrl_meas !== 8'hB7) begin bad++; $display("FAIL ctrl_wr: got %h want b7", ctrl_meas); end
        read_setup(CTRL_MEAS_REG, acks);
        rd_byte(1'b1, d);
        i2c_stop();
        total++; if (d !== 8'hB7) begin bad++; $display("FAIL ctrl_readback: got %h want b7", d); end
        p0 = pulse_cnt;
        write_reg(RESET_REG, 8'hB6, acks);
        total++; if (pulse_cnt - p0 !== 1) begin bad++; $display("FAIL soft_reset_pulse: got %0d cycles want 1", pulse_cnt - p0); end
        total++; if (ctrl_meas !== 8'h00) begin bad++; $display("FAIL soft_reset_ctrl: got %h want 00", ctrl_meas); end
        write_reg(CTRL_MEAS_REG, 8'h25, acks);
        p0 = pulse_cnt;
        write_reg(RESET_REG, 8'h12, acks);
        total++; if (pulse_cnt - p0 !== 0) begin bad++; $display("FAIL bad_magic_pulse: got %0d cycles want 0", pulse_cnt - p0); end
        total++; if (ctrl_meas !== 8'h25) begin bad++; $display("FAIL bad_magic_ctrl: got %h want 25", ctrl_meas); end
    endtask

    task automatic test_burst_temp();
        logic [2:0] acks;
        logic [7:0] d;
        temp_raw = 20'h81234;
        read_setup(TEMP_MSB, acks);
        rd_byte(1'b0, d);
        total++; if (d !== 8'h81) begin bad++; $display("FAIL temp_b0: got %h want 81", d); end
        temp_raw = 20'hFFFFF;
        rd_byte(1'b0, d);
        total++; if (d !== 8'h23) begin bad++; $display("FAIL temp_b1: got %h want 23", d); end
        rd_byte(1'b1, d);
        total++; if (d !== 8'h40) begin bad++; $display("FAIL temp_b2: got %h want 40", d); end
        i2c_stop();
        read_setup(TEMP_MSB, acks);
        rd_byte(1'b0, d);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL temp2_b0: got %h want ff", d); end
        rd_byte(1'b0, d);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL temp2_b1: got %h want ff", d); end
        rd_byte(1'b1, d);
        total++; if (d !== 8'hF0) begin bad++; $display("FAIL temp2_b2: got %h want f0", d); end
        i2c_stop();
        press_raw = 20'hABCDE;
        read_setup(PRESS_MSB, acks);
        rd_byte(1'b0, d);
        total++; if (d !== 8'hAB) begin bad++; $display("FAIL press_b0: got %h want ab", d); end
        rd_byte(1'b0, d);
        total++; if (d !== 8'hCD) begin bad++; $display("FAIL press_b1: got %h want cd", d); end
        rd_byte(1'b1, d);
        total++; if (d !== 8'hE0) begin bad++; $display("FAIL press_b2: got %h want e0", d); end
        i2c_stop();
    endtask

    task automatic test_calib();
        logic [2:0] acks;
        logic [7:0] d;
        read_setup(CALIB_BASE, acks);
        for (int k = 0; k < 26; k++) begin
            rd_byte(k == 25, d);
            total++;
            if (d !== 8'(k + 1)) begin bad++; $display("FAIL calib_%0d: got %h want %h", k, d, 8'(k + 1)); end
        end
        i2c_stop();
        read_setup(8'hFF, acks);
        rd_byte(1'b0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reg_ff: got %h want 00", d); end
        rd_byte(1'b1, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reg_00_wrap: got %h want 00", d); end
        i2c_stop();
        total++; if (u_dut.pointer_r !== 8'h00) begin bad++; $display("FAIL ptr_wrap: got %h want 00", u_dut.pointer_r); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1, a2;
        int oe0;
        oe0 = oe_cnt;
        i2c_start();
        wr_byte(8'hEE, a0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrong_busy: got %b want 0", busy); end
        wr_byte(CTRL_MEAS_REG, a1);
        wr_byte(8'h00, a2);
        i2c_stop();
        total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL wrong_acks: got %b want 111", {a0, a1, a2}); end
        total++; if (oe_cnt - oe0 !== 0) begin bad++; $display("FAIL wrong_sda_oe: got %0d cycles want 0", oe_cnt - oe0); end
        total++; if (ctrl_meas !== 8'h25) begin bad++; $display("FAIL wrong_ctrl: got %h want 25", ctrl_meas); end
    endtask

    task automatic test_reset_mid_read();
        logic [2:0] acks;
        read_setup(CHIP_ID_REG, acks);
        total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL midrd_drive: got %b want 1", sda_oe); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL midrd_release: got %b want 0", sda_oe); end
        total++; if (u_dut.state_r !== ST_IDLE) begin bad++; $display("FAIL midrd_state: got %0d want %0d", u_dut.state_r, ST_IDLE); end
        @(posedge clk); #1;
        rst = 1'b0;
        sda_ctrl = 1'b1;
        scl = 1'b1;
        wq();
        total++; if (ctrl_meas !== 8'h00) begin bad++; $display("FAIL midrd_ctrl: got %h want 00", ctrl_meas); end
        test_chip_id("after_rst");
    endtask

    initial begin
        for (int k = 0; k < 26; k++) calib_data[8*k +: 8] = 8'(k + 1);
        test_reset();
        test_chip_id("chip_id");
        test_ctrl_meas();
        test_burst_temp();
        test_calib();
        test_wrong_addr();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
